// File: rtl/riscv_pkg.sv
// Shared RISC-V decode helpers: extension mode encodings and immediate
// bit-slice functions, each returning a 32-bit sign-extended immediate.
package riscv_pkg;

  localparam logic [2:0] MODE_ZERO  = 3'd0;
  localparam logic [2:0] MODE_SIGN  = 3'd1;
  localparam logic [2:0] MODE_IMM_I = 3'd2;
  localparam logic [2:0] MODE_IMM_S = 3'd3;
  localparam logic [2:0] MODE_IMM_B = 3'd4;
  localparam logic [2:0] MODE_IMM_U = 3'd5;
  localparam logic [2:0] MODE_IMM_J = 3'd6;
  localparam logic [2:0] MODE_RSVD  = 3'd7;

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] instr);
    return {{20{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {instr[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/imm_extend_stage_if.sv
// Handshake bundle for the extension stage: upstream beat in, extended result out.
interface imm_extend_stage_if #(
  parameter int XLEN = 32,
  parameter int IN_W = 16
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_mode;
  logic [IN_W-1:0] in_data;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_data;
  logic            out_err;

  // master drives beats and consumes results; slave is the stage itself
  modport master (
    output in_valid, in_mode, in_data, in_instr, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_mode, in_data, in_instr, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/imm_extend_comb.sv
// Pure combinational extension mux: generic zero/sign extension of an IN_W
// field and RISC-V I/S/B/U/J immediate extraction, all widened to XLEN.
module imm_extend_comb
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IN_W = 16
) (
  input  logic [2:0]      mode,
  input  logic [IN_W-1:0] data,
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] result,
  output logic            err
);

  // opcode bits never contribute to an immediate
  logic unused_opcode;
  assign unused_opcode = ^instr[6:0];

  // size casts extend according to operand signedness
  always_comb begin
    result = '0;
    err    = 1'b0;
    case (mode)
      MODE_ZERO:  result = XLEN'(data);
      MODE_SIGN:  result = XLEN'($signed(data));
      MODE_IMM_I: result = XLEN'($signed(imm_i(instr)));
      MODE_IMM_S: result = XLEN'($signed(imm_s(instr)));
      MODE_IMM_B: result = XLEN'($signed(imm_b(instr)));
      MODE_IMM_U: result = XLEN'($signed(imm_u(instr)));
      MODE_IMM_J: result = XLEN'($signed(imm_j(instr)));
      default:    err    = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_stage.sv
// Registered extension stage with a two-entry skid buffer (output register +
// skid register) so in_ready depends only on registered state.
module imm_extend_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int IN_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  imm_extend_stage_if.slave   bus
);

  generate
    if (!(XLEN == 32 || XLEN == 64) || IN_W < 1 || IN_W > XLEN) begin : g_bad_param
      $error("imm_extend_stage: illegal XLEN=%0d / IN_W=%0d", XLEN, IN_W);
    end
  endgenerate

  logic [XLEN-1:0] ext_result;
  logic            ext_err;

  imm_extend_comb #(
    .XLEN (XLEN),
    .IN_W (IN_W)
  ) u_comb (
    .mode   (bus.in_mode),
    .data   (bus.in_data),
    .instr  (bus.in_instr),
    .result (ext_result),
    .err    (ext_err)
  );

  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] out_data_q,  out_data_d;
  logic            out_err_q,   out_err_d;
  logic            skid_valid_q, skid_valid_d;
  logic [XLEN-1:0] skid_data_q,  skid_data_d;
  logic            skid_err_q,   skid_err_d;

  logic accept;
  logic out_free;

  assign bus.in_ready  = !skid_valid_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_err   = out_err_q;

  assign accept   = bus.in_valid && !skid_valid_q;
  assign out_free = !out_valid_q || bus.out_ready;

  // skid can only fill while the output is held, and in_ready is low while
  // it is full, so draining the skid and accepting never coincide
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_err_d    = out_err_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_err_d   = skid_err_q;

    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_err_d    = skid_err_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_data_d  = ext_result;
        out_err_d   = ext_err;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ext_result;
      skid_err_d   = ext_err;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_err_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_err_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_err_q    <= out_err_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_err_q   <= skid_err_d;
    end
  end

endmodule

// File: tb/tb_imm_extend_stage.sv
// Directed bench for imm_extend_stage at XLEN=32 and XLEN=64 (IN_W=16),
// both instances driven with identical stimulus.
module tb_imm_extend_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  in_mode;
  logic [15:0] in_data;
  logic [31:0] in_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_extend_stage_if #(.XLEN(32), .IN_W(16)) bus32 ();
  imm_extend_stage_if #(.XLEN(64), .IN_W(16)) bus64 ();

  assign bus32.in_valid  = in_valid;
  assign bus32.in_mode   = in_mode;
  assign bus32.in_data   = in_data;
  assign bus32.in_instr  = in_instr;
  assign bus32.out_ready = out_ready;
  assign bus64.in_valid  = in_valid;
  assign bus64.in_mode   = in_mode;
  assign bus64.in_data   = in_data;
  assign bus64.in_instr  = in_instr;
  assign bus64.out_ready = out_ready;

  imm_extend_stage #(.XLEN(32), .IN_W(16)) dut32 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus32)
  );

  imm_extend_stage #(.XLEN(64), .IN_W(16)) dut64 (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [2:0] m, input logic [15:0] d, input logic [31:0] ins);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    in_instr = ins;
  endtask

  // present one beat at a negedge, then check both outputs one edge later
  task automatic beat(input string tag, input logic [2:0] m, input logic [15:0] d,
                      input logic [31:0] ins, input logic [31:0] e32,
                      input logic [63:0] e64, input logic eerr);
    present(m, d, ins);
    @(negedge clk);
    in_valid = 1'b0;
    chk({tag, " valid32"}, {63'd0, bus32.out_valid}, 64'd1);
    chk({tag, " data32"},  {32'd0, bus32.out_data}, {32'd0, e32});
    chk({tag, " err32"},   {63'd0, bus32.out_err},  {63'd0, eerr});
    chk({tag, " valid64"}, {63'd0, bus64.out_valid}, 64'd1);
    chk({tag, " data64"},  bus64.out_data, e64);
  endtask

  task automatic chk_hs(input string tag, input logic ev, input logic er);
    chk({tag, " out_valid"}, {63'd0, bus32.out_valid}, {63'd0, ev});
    chk({tag, " in_ready"},  {63'd0, bus32.in_ready},  {63'd0, er});
    chk({tag, " out_valid64"}, {63'd0, bus64.out_valid}, {63'd0, ev});
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_mode = 3'd0; in_data = '0; in_instr = '0;

    #12;
    chk_hs("reset", 1'b0, 1'b1);
    chk("reset data32", {32'd0, bus32.out_data}, 64'd0);
    chk("reset err32", {63'd0, bus32.out_err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_hs("post-reset", 1'b0, 1'b1);

    beat("zero", MODE_ZERO, 16'h8001, 32'h0, 32'h0000_8001, 64'h0000_0000_0000_8001, 1'b0);
    beat("sign", MODE_SIGN, 16'h8001, 32'h0, 32'hFFFF_8001, 64'hFFFF_FFFF_FFFF_8001, 1'b0);
    beat("sign_pos", MODE_SIGN, 16'h7FFE, 32'h0, 32'h0000_7FFE, 64'h0000_0000_0000_7FFE, 1'b0);
    beat("imm_i", MODE_IMM_I, 16'h0, 32'hFFF0_0093, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    beat("imm_s", MODE_IMM_S, 16'h0, 32'hFE11_2E23, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    beat("imm_b", MODE_IMM_B, 16'h0, 32'hFE00_0EE3, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    beat("imm_j", MODE_IMM_J, 16'h0, 32'h0080_006F, 32'h0000_0008, 64'h0000_0000_0000_0008, 1'b0);
    beat("imm_u", MODE_IMM_U, 16'h0, 32'h8000_00B7, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    beat("rsvd", MODE_RSVD, 16'hFFFF, 32'hFFFF_FFFF, 32'h0, 64'h0, 1'b1);
    chk("rsvd err64", {63'd0, bus64.out_err}, 64'd1);
    @(negedge clk);
    chk_hs("drain", 1'b0, 1'b1);

    // back-pressure: A held in output, B into skid, C refused
    out_ready = 1'b0;
    present(MODE_ZERO, 16'h0011, 32'h0);
    @(negedge clk);
    chk_hs("bp A held", 1'b1, 1'b1);
    present(MODE_ZERO, 16'h0022, 32'h0);
    @(negedge clk);
    chk_hs("bp B skid", 1'b1, 1'b0);
    chk("bp A stable", {32'd0, bus32.out_data}, 64'h11);
    present(MODE_ZERO, 16'h0033, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    chk_hs("bp C refused", 1'b1, 1'b0);
    chk("bp A still", {32'd0, bus32.out_data}, 64'h11);
    out_ready = 1'b1;
    @(negedge clk);
    chk_hs("bp B out", 1'b1, 1'b1);
    chk("bp B data", {32'd0, bus32.out_data}, 64'h22);
    chk("bp B data64", bus64.out_data, 64'h22);
    @(negedge clk);
    chk_hs("bp empty", 1'b0, 1'b1);

    // flush with both entries full and a beat presented
    out_ready = 1'b0;
    present(MODE_ZERO, 16'h00A1, 32'h0);
    @(negedge clk);
    present(MODE_ZERO, 16'h00B2, 32'h0);
    @(negedge clk);
    chk_hs("fl full", 1'b1, 1'b0);
    present(MODE_ZERO, 16'h0044, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk_hs("fl cleared", 1'b0, 1'b1);
    chk("fl data held", {32'd0, bus32.out_data}, 64'hA1);
    present(MODE_ZERO, 16'h0055, 32'h0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk_hs("fl drop ready", 1'b0, 1'b1);
    @(negedge clk);
    chk_hs("fl no ghost", 1'b0, 1'b1);
    beat("fl C", MODE_ZERO, 16'h0066, 32'h0, 32'h0000_0066, 64'h66, 1'b0);

    // asynchronous reset mid-stall
    out_ready = 1'b0;
    present(MODE_ZERO, 16'h0077, 32'h0);
    @(negedge clk);
    present(MODE_ZERO, 16'h0088, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    chk_hs("rst pre", 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_hs("rst async", 1'b0, 1'b1);
    chk("rst async data", {32'd0, bus32.out_data}, 64'd0);
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk_hs("rst no replay", 1'b0, 1'b1);
    @(negedge clk);
    chk_hs("rst no replay2", 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
